// File: rtl/latch_write_seq.sv
// Write sequencer for a bank of level-sensitive D latches with guaranteed setup/pulse/hold windows.
// Optional broadcast writes are enabled by defining LATCH_WRITE_SEQ_BROADCAST_EN (adds in_bcast).
`timescale 1ns/1ps
module latch_write_seq #(
    parameter int DATA_W    = 8,
    parameter int NUM_LATCH = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    localparam int ADDR_W   = $clog2(NUM_LATCH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic [DATA_W-1:0]    in_data,
`ifdef LATCH_WRITE_SEQ_BROADCAST_EN
    input  logic                 in_bcast,
`endif
    output logic [DATA_W-1:0]    lat_d,
    output logic [NUM_LATCH-1:0] lat_en,
    output logic                 busy,
    output logic                 err
);

    localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                bcast_reg;
    logic                bcast_req;
    logic                addr_ok;
    logic [NUM_LATCH-1:0] onehot;

`ifdef LATCH_WRITE_SEQ_BROADCAST_EN
    assign bcast_req = in_bcast;
`else
    assign bcast_req = 1'b0;
`endif

    // Broadcast writes skip the range check entirely.
    assign addr_ok = bcast_req || (int'(in_addr) < NUM_LATCH);

    // Decode comes from the stored address; it only reaches lat_en through a flop.
    for (genvar gi = 0; gi < NUM_LATCH; gi++) begin : g_onehot
        assign onehot[gi] = (addr_reg == ADDR_W'(gi));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            bcast_reg <= 1'b0;
            lat_d     <= '0;
            lat_en    <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (addr_ok) begin
                            addr_reg  <= in_addr;
                            bcast_reg <= bcast_req;
                            lat_d     <= in_data;
                            cnt_reg   <= CNT_W'(SETUP_CYC - 1);
                            state_reg <= SETUP;
                            busy      <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (cnt_reg == '0) begin
                        cnt_reg   <= CNT_W'(PULSE_CYC - 1);
                        state_reg <= PULSE;
                        lat_en    <= bcast_reg ? '1 : onehot;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt_reg == '0) begin
                        cnt_reg   <= CNT_W'(HOLD_CYC - 1);
                        state_reg <= HOLD;
                        lat_en    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_reg == '0) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    lat_en    <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_write_seq.sv
// Self-checking bench for latch_write_seq: directed vector table, corner sequences and
// randomized traffic against a window-arithmetic reference model (4-latch and 3-latch instances).
`timescale 1ns/1ps
module tb_latch_write_seq;

    localparam int S = 1, P = 2, H = 1;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic       a_valid = 0, a_ready, a_busy, a_err, a_bcast = 0;
    logic [1:0] a_addr = 0;
    logic [7:0] a_data = 0, a_d;
    logic [3:0] a_en;

    logic       b_valid = 0, b_ready, b_busy, b_err, b_bcast = 0;
    logic [1:0] b_addr = 0;
    logic [7:0] b_data = 0, b_d;
    logic [2:0] b_en;

    latch_write_seq #(.DATA_W(8), .NUM_LATCH(4), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) dut (
        .clk(clk), .rstn(rstn),
`ifdef LATCH_WRITE_SEQ_BROADCAST_EN
        .in_bcast(a_bcast),
`endif
        .in_valid(a_valid), .in_ready(a_ready), .in_addr(a_addr), .in_data(a_data),
        .lat_d(a_d), .lat_en(a_en), .busy(a_busy), .err(a_err)
    );

    latch_write_seq #(.DATA_W(8), .NUM_LATCH(3), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) dut3 (
        .clk(clk), .rstn(rstn),
`ifdef LATCH_WRITE_SEQ_BROADCAST_EN
        .in_bcast(b_bcast),
`endif
        .in_valid(b_valid), .in_ready(b_ready), .in_addr(b_addr), .in_data(b_data),
        .lat_d(b_d), .lat_en(b_en), .busy(b_busy), .err(b_err)
    );

    // Reference model: time elapsed since the accept edge decides every window.
    typedef struct {
        bit         idle;
        int         t;
        int         addr;
        logic [7:0] d;
        bit         err;
        bit         ready;
        bit         bc;
    } model_t;

    model_t ma, mb;
    int total = 0, bad = 0;
    logic [3:0] prev_en = 0;
    logic [7:0] prev_d = 0;

    function automatic model_t mreset();
        model_t n;
        n.idle = 1; n.t = 0; n.addr = 0; n.d = 8'h00; n.err = 0; n.ready = 0; n.bc = 0;
        return n;
    endfunction

    function automatic model_t mstep(model_t m, bit in_rst, bit v, int addr, logic [7:0] data,
                                     bit bc, int nl);
        model_t n = m;
        if (in_rst) return mreset();
        n.err = 0;
        if (m.idle) begin
            if (v && m.ready) begin
                if (bc || addr < nl) begin
                    n.idle = 0; n.t = 0; n.addr = addr; n.d = data; n.bc = bc;
                end else begin
                    n.err = 1;
                end
            end
        end else begin
            n.t = m.t + 1;
            if (n.t == S + P + H) n.idle = 1;
        end
        n.ready = n.idle;
        return n;
    endfunction

    function automatic logic [15:0] men(model_t m, int nl);
        if (!m.idle && m.t >= S && m.t < S + P)
            return m.bc ? 16'((32'd1 << nl) - 1) : 16'(32'd1 << m.addr);
        return 16'h0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        logic [15:0] ea, eb;
        ea = men(ma, 4);
        eb = men(mb, 3);
        chk("dut4_outputs", 32'({a_ready, a_busy, a_err, a_en, a_d}),
            32'({ma.ready, ~ma.idle, ma.err, ea[3:0], ma.d}));
        chk("dut3_outputs", 32'({b_ready, b_busy, b_err, b_en, b_d}),
            32'({mb.ready, ~mb.idle, mb.err, eb[2:0], mb.d}));
        if (rstn && (prev_en != 0 || a_en != 0))
            chk("lat_d_stable_around_enable", 32'(a_d), 32'(prev_d));
        prev_en = a_en;
        prev_d  = a_d;
    endtask

    // Advance the model across the coming rising edge, then sample on the falling edge.
    task automatic cyc();
        ma = mstep(ma, !rstn, a_valid, int'(a_addr), a_data, a_bcast, 4);
        mb = mstep(mb, !rstn, b_valid, int'(b_addr), b_data, b_bcast, 3);
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset_now();
        rstn = 1'b0;
        ma = mreset();
        mb = mreset();
        prev_en = 0;
        prev_d  = 0;
    endtask

    typedef struct packed {
        logic       v;
        logic [1:0] addr;
        logic [7:0] data;
        logic [3:0] en;
        logic [7:0] d;
        logic       ready;
        logic       busy;
        logic       err;
    } vec_t;

    localparam int NV = 15;
    vec_t tv [NV];

    initial begin
        // Single write to latch 2, ignored change while busy, a write to latch 3,
        // then a held request that is taken only on the IDLE-return cycle.
        tv[0]  = '{1'b1, 2'd2, 8'hA5, 4'h0, 8'hA5, 1'b0, 1'b1, 1'b0};
        tv[1]  = '{1'b1, 2'd1, 8'h3C, 4'h4, 8'hA5, 1'b0, 1'b1, 1'b0};
        tv[2]  = '{1'b0, 2'd0, 8'h00, 4'h4, 8'hA5, 1'b0, 1'b1, 1'b0};
        tv[3]  = '{1'b0, 2'd0, 8'h00, 4'h0, 8'hA5, 1'b0, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 2'd0, 8'h00, 4'h0, 8'hA5, 1'b1, 1'b0, 1'b0};
        tv[5]  = '{1'b1, 2'd3, 8'h33, 4'h0, 8'h33, 1'b0, 1'b1, 1'b0};
        tv[6]  = '{1'b1, 2'd3, 8'h33, 4'h8, 8'h33, 1'b0, 1'b1, 1'b0};
        tv[7]  = '{1'b0, 2'd0, 8'h00, 4'h8, 8'h33, 1'b0, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 2'd0, 8'h00, 4'h0, 8'h33, 1'b0, 1'b1, 1'b0};
        tv[9]  = '{1'b1, 2'd0, 8'h11, 4'h0, 8'h33, 1'b1, 1'b0, 1'b0};
        tv[10] = '{1'b1, 2'd0, 8'h11, 4'h0, 8'h11, 1'b0, 1'b1, 1'b0};
        tv[11] = '{1'b0, 2'd0, 8'h00, 4'h1, 8'h11, 1'b0, 1'b1, 1'b0};
        tv[12] = '{1'b0, 2'd0, 8'h00, 4'h1, 8'h11, 1'b0, 1'b1, 1'b0};
        tv[13] = '{1'b0, 2'd0, 8'h00, 4'h0, 8'h11, 1'b0, 1'b1, 1'b0};
        tv[14] = '{1'b0, 2'd0, 8'h00, 4'h0, 8'h11, 1'b1, 1'b0, 1'b0};

        // Reset: assert asynchronously, hold with a pending request that must be ignored.
        #2;
        async_reset_now();
        a_valid = 1; a_addr = 2'd1; a_data = 8'hFF;
        @(negedge clk);
        check_all();
        repeat (2) cyc();
        chk("reset_outputs_zero", 32'({a_ready, a_busy, a_err, a_en, a_d}), 32'd0);
        rstn = 1'b1;
        a_valid = 0;
        cyc();
        chk("ready_after_release", 32'(a_ready), 32'd1);

        for (int k = 0; k < NV; k++) begin
            a_valid = tv[k].v; a_addr = tv[k].addr; a_data = tv[k].data;
            cyc();
            chk($sformatf("vec%0d", k), 32'({a_en, a_d, a_ready, a_busy, a_err}),
                32'({tv[k].en, tv[k].d, tv[k].ready, tv[k].busy, tv[k].err}));
        end
        a_valid = 0;

        // Back-to-back with in_valid held: second request accepted off the IDLE-return cycle.
        a_valid = 1; a_addr = 2'd0; a_data = 8'h11;
        cyc();
        a_addr = 2'd3; a_data = 8'h33;
        repeat (4) cyc();
        chk("b2b_ready_cycle4", 32'({a_ready, a_busy, a_d}), 32'({1'b1, 1'b0, 8'h11}));
        cyc();
        chk("b2b_second_accept", 32'({a_busy, a_d}), 32'({1'b1, 8'h33}));
        a_valid = 0;
        repeat (5) cyc();

        // Out-of-range address on the 3-latch instance.
        b_valid = 1; b_addr = 2'd1; b_data = 8'h42;
        cyc();
        b_valid = 0;
        repeat (5) cyc();
        b_valid = 1; b_addr = 2'd3; b_data = 8'hEE;
        cyc();
        chk("oor_err_pulse", 32'({b_err, b_en, b_d, b_ready, b_busy}),
            32'({1'b1, 3'b000, 8'h42, 1'b1, 1'b0}));
        b_valid = 0;
        cyc();
        chk("oor_err_one_cycle", 32'({b_err, b_en, b_d}), 32'({1'b0, 3'b000, 8'h42}));

        // Asynchronous reset while the enable is high.
        a_valid = 1; a_addr = 2'd2; a_data = 8'hC3;
        cyc();
        a_valid = 0;
        cyc();
        chk("pulse_before_reset", 32'(a_en), 32'h4);
        #2;
        async_reset_now();
        #1;
        chk("async_reset_drops_en", 32'({a_en, a_busy, a_d}), 32'd0);
        cyc();
        rstn = 1'b1;
        cyc();
        a_valid = 1; a_addr = 2'd1; a_data = 8'h77;
        cyc();
        a_valid = 0;
        cyc();
        chk("write_after_reset", 32'({a_en, a_d}), 32'({4'h2, 8'h77}));
        repeat (4) cyc();

`ifdef LATCH_WRITE_SEQ_BROADCAST_EN
        a_bcast = 1; a_valid = 1; a_addr = 2'd1; a_data = 8'h5A;
        cyc();
        a_bcast = 0; a_valid = 0;
        cyc();
        chk("bcast_en_c1", 32'({a_en, a_err, a_d}), 32'({4'hF, 1'b0, 8'h5A}));
        cyc();
        chk("bcast_en_c2", 32'({a_en, a_err}), 32'({4'hF, 1'b0}));
        repeat (3) cyc();
`endif

        // Randomized traffic on both instances, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                async_reset_now();
                cyc();
                rstn = 1'b1;
            end
            a_valid = 1'($urandom_range(0, 1));
            a_addr  = 2'($urandom_range(0, 3));
            a_data  = 8'($urandom);
            b_valid = 1'($urandom_range(0, 1));
            b_addr  = 2'($urandom_range(0, 3));
            b_data  = 8'($urandom);
`ifdef LATCH_WRITE_SEQ_BROADCAST_EN
            a_bcast = ($urandom_range(0, 3) == 0);
            b_bcast = ($urandom_range(0, 3) == 0);
`endif
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
